// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the Bridge data bus with WAIT_STATES extra cycles per transfer.
// Optional macro BUS_LOCK_EN lets a locked master 1 keep the bus for up to LOCK_MAX consecutive grants.
module bus_arbiter #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned LOCK_MAX    = 8
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_stall_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic        m1_lock_i,
    output logic        m1_gnt_o,
    output logic        m1_done_o,
    output logic [31:0] m1_rdata_o,
    output logic [31:0] Bus_addr_o,
    output logic        Bus_we_o,
    output logic [31:0] Bus_wdata_o,
    input  logic [31:0] Bus_rdata_i,
    output logic [1:0]  grant_o
);

    // State encoding doubles as the grant_o encoding.
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_XFER_M0 = 2'b01;
    localparam logic [1:0] ST_XFER_M1 = 2'b10;
    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        we_lat_q, we_lat_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        bus_we_q, bus_we_d;
    logic        m1_gnt_q, m1_gnt_d;
    logic        m1_done_q, m1_done_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        pick_m1_s;
    logic        done_m0_s;
    logic        done_m1_s;
    logic        lock_win_s;

`ifdef BUS_LOCK_EN
    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);
    logic [7:0] lock_cnt_q, lock_cnt_d;

    // Master 1 keeps the bus while it holds the lock and has not used up its grant budget.
    always_comb begin
        lock_win_s = last_q & m1_lock_i & (lock_cnt_q < LOCK_LIMIT);
    end
`else
    logic lock_unused_s;

    // Lock input is not used in this build.
    always_comb begin
        lock_win_s    = 1'b0;
        lock_unused_s = m1_lock_i ^ (LOCK_MAX == 0);
    end
`endif

    // Arbitration between the two requesters; ties go to whoever did not own the bus last.
    always_comb begin
        if (m1_req_i && !m0_req_i) begin
            pick_m1_s = 1'b1;
        end else if (m1_req_i && m0_req_i) begin
            pick_m1_s = lock_win_s | ~last_q;
        end else begin
            pick_m1_s = 1'b0;
        end
    end

    // Done-cycle decode used for the rdata bypass and the CPU stall.
    always_comb begin
        done_m0_s = (state_q == ST_XFER_M0) && (cnt_q == 4'd0);
        done_m1_s = (state_q == ST_XFER_M1) && (cnt_q == 4'd0);
    end

    // Next-state logic; write strobe and done pulse are computed one cycle early so they leave flops.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        we_lat_d   = we_lat_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bus_we_d   = 1'b0;
        m1_gnt_d   = 1'b0;
        m1_done_d  = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef BUS_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    cnt_d = WAIT_INIT;
                    if (pick_m1_s) begin
                        state_d  = ST_XFER_M1;
                        last_d   = 1'b1;
                        we_lat_d = m1_we_i;
                        addr_d   = m1_addr_i;
                        wdata_d  = m1_wdata_i;
                        m1_gnt_d = 1'b1;
`ifdef BUS_LOCK_EN
                        lock_cnt_d = (lock_cnt_q == 8'hFF) ? lock_cnt_q : lock_cnt_q + 8'd1;
`endif
                    end else begin
                        state_d  = ST_XFER_M0;
                        last_d   = 1'b0;
                        we_lat_d = m0_we_i;
                        addr_d   = m0_addr_i;
                        wdata_d  = m0_wdata_i;
`ifdef BUS_LOCK_EN
                        lock_cnt_d = 8'd0;
`endif
                    end
                    if (WAIT_INIT == 4'd0) begin
                        bus_we_d  = pick_m1_s ? m1_we_i : m0_we_i;
                        m1_done_d = pick_m1_s;
                    end else begin
                        bus_we_d  = 1'b0;
                        m1_done_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER_M0, ST_XFER_M1: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_XFER_M1) begin
                        m1_rdata_d = Bus_rdata_i;
                    end else begin
                        m0_rdata_d = Bus_rdata_i;
                    end
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    m1_gnt_d = (state_q == ST_XFER_M1);
                    if (cnt_q == 4'd1) begin
                        bus_we_d  = we_lat_q;
                        m1_done_d = (state_q == ST_XFER_M1);
                    end else begin
                        bus_we_d  = 1'b0;
                        m1_done_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer and kills a pending strobe at once.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            last_q     <= 1'b1;
            we_lat_q   <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            bus_we_q   <= 1'b0;
            m1_gnt_q   <= 1'b0;
            m1_done_q  <= 1'b0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            we_lat_q   <= we_lat_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bus_we_q   <= bus_we_d;
            m1_gnt_q   <= m1_gnt_d;
            m1_done_q  <= m1_done_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

`ifdef BUS_LOCK_EN
    // Consecutive master-1 grant counter.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            lock_cnt_q <= 8'd0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    assign grant_o     = state_q;
    assign Bus_addr_o  = addr_q;
    assign Bus_wdata_o = wdata_q;
    assign Bus_we_o    = bus_we_q;
    assign m1_gnt_o    = m1_gnt_q;
    assign m1_done_o   = m1_done_q;
    assign m0_rdata_o  = done_m0_s ? Bus_rdata_i : m0_rdata_q;
    assign m1_rdata_o  = done_m1_s ? Bus_rdata_i : m1_rdata_q;
    assign m0_stall_o  = m0_req_i & ~done_m0_s;

endmodule
